// File: rtl/vga_timing_gen_pkg.sv
// vga_pkg: shared timing/colour types and constants for the VGA scan generator.
package vga_pkg;

  // One axis worth of timing, in pixels or lines.
  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480 = '{16'd640, 16'd16, 16'd96, 16'd48};
  localparam vga_timing_t VGA_800x600 = '{16'd800, 16'd40, 16'd128, 16'd88};

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam rgb565_t RGB_WHITE   = '{5'd31, 6'd63, 5'd31};
  localparam rgb565_t RGB_YELLOW  = '{5'd31, 6'd63, 5'd0};
  localparam rgb565_t RGB_CYAN    = '{5'd0,  6'd63, 5'd31};
  localparam rgb565_t RGB_GREEN   = '{5'd0,  6'd63, 5'd0};
  localparam rgb565_t RGB_MAGENTA = '{5'd31, 6'd0,  5'd31};
  localparam rgb565_t RGB_RED     = '{5'd31, 6'd0,  5'd0};
  localparam rgb565_t RGB_BLUE    = '{5'd0,  6'd0,  5'd31};
  localparam rgb565_t RGB_BLACK   = '{5'd0,  6'd0,  5'd0};

  // Colour of bar idx, left to right.
  function automatic rgb565_t bar_colour(input logic [2:0] idx);
    rgb565_t c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// vga_axis_counter: one scan axis. Counts 0..TOTAL-1 when advanced and
// decodes wrap, active region and (active-high) sync region from the count.
module vga_axis_counter #(
  parameter int CW     = 11,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_adv,
  output logic [CW-1:0] o_cnt,
  output logic          o_wrap,
  output logic          o_active,
  output logic          o_sync
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  // Decode is done one bit wider so a sync end equal to 2^CW still compares correctly.
  localparam logic [CW:0] C_LAST  = (CW+1)'(TOTAL - 1);
  localparam logic [CW:0] C_ACT   = (CW+1)'(ACTIVE);
  localparam logic [CW:0] C_SBEG  = (CW+1)'(ACTIVE + FP);
  localparam logic [CW:0] C_SEND  = (CW+1)'(ACTIVE + FP + SYNC);

  logic [CW-1:0] r_cnt;
  logic [CW:0]   w_cnt_x;

  assign w_cnt_x  = {1'b0, r_cnt};
  assign o_cnt    = r_cnt;
  assign o_wrap   = (w_cnt_x == C_LAST);
  assign o_active = (w_cnt_x < C_ACT);
  assign o_sync   = (w_cnt_x >= C_SBEG) && (w_cnt_x < C_SEND);

  // Position counter, wrapping at the last position of the axis.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_adv) begin
      r_cnt <= o_wrap ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA scan generator with registered, mutually
// aligned coordinates, syncs, de, line/frame strobes and frame counter.
// Define VGA_TIMING_PATTERN_EN to add an 8-bar colour test pattern on pat_*.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CW       = 11,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int FRAME_CW = 16
) (
  input  logic                clk_pix,
  input  logic                rst_pix,
  input  logic                en,
  output logic [CW-1:0]       sx,
  output logic [CW-1:0]       sy,
  output logic                hsync,
  output logic                vsync,
  output logic                de,
  output logic                line_start,
  output logic                frame_start,
  output logic [FRAME_CW-1:0] frame_cnt,
  output logic [4:0]          pat_r,
  output logic [5:0]          pat_g,
  output logic [4:0]          pat_b
);

  localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic HS_ACT  = (HS_POL != 0);
  localparam logic VS_ACT  = (VS_POL != 0);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
    $error("vga_timing_gen: timing parameters must be non-zero");
  end
  if (H_TOTAL > (2 ** CW) || V_TOTAL > (2 ** CW)) begin : g_bad_width
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the CW counter range");
  end

  logic [CW-1:0]       w_hc, w_vc;
  logic                w_h_wrap, w_v_wrap, w_h_act, w_v_act, w_h_sync, w_v_sync;
  logic [FRAME_CW-1:0] r_frame_ctr;

  vga_axis_counter #(
    .CW(CW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .i_clk(clk_pix), .i_rst(rst_pix), .i_adv(en),
    .o_cnt(w_hc), .o_wrap(w_h_wrap), .o_active(w_h_act), .o_sync(w_h_sync)
  );

  // The vertical axis steps once per completed line.
  vga_axis_counter #(
    .CW(CW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .i_clk(clk_pix), .i_rst(rst_pix), .i_adv(en & w_h_wrap),
    .o_cnt(w_vc), .o_wrap(w_v_wrap), .o_active(w_v_act), .o_sync(w_v_sync)
  );

  // Output stage: latch the decode of the current counters; strobes are single-shot.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      sx          <= '0;
      sy          <= '0;
      hsync       <= ~HS_ACT;
      vsync       <= ~VS_ACT;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      r_frame_ctr <= '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (en) begin
        sx          <= w_hc;
        sy          <= w_vc;
        hsync       <= w_h_sync ? HS_ACT : ~HS_ACT;
        vsync       <= w_v_sync ? VS_ACT : ~VS_ACT;
        de          <= w_h_act & w_v_act;
        line_start  <= (w_hc == '0);
        frame_start <= (w_hc == '0) && (w_vc == '0);
        // frame_cnt shows the count of the frame the pixel belongs to, so the
        // internal count moves ahead on the wrap and the output follows one step later.
        frame_cnt   <= r_frame_ctr;
        if (w_h_wrap && w_v_wrap) begin
          r_frame_ctr <= r_frame_ctr + FRAME_CW'(1);
        end
      end
    end
  end

`ifdef VGA_TIMING_PATTERN_EN
  logic [2:0] w_bar;

  // Bar index: highest k whose left edge k*H_ACTIVE/8 lies at or before hc.
  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({1'b0, w_hc} >= (CW+1)'(k * H_ACTIVE / 8)) begin
        w_bar = 3'(k);
      end
    end
  end

  // Pattern register, aligned with de and black outside the active area.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      {pat_r, pat_g, pat_b} <= '0;
    end else if (en) begin
      {pat_r, pat_g, pat_b} <= (w_h_act & w_v_act) ? bar_colour(w_bar) : RGB_BLACK;
    end
  end
`else
  assign pat_r = '0;
  assign pat_g = '0;
  assign pat_b = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default-timing instance and a small
// positive-polarity instance with a 2-bit frame counter.
module tb_vga_timing_gen;

  typedef struct {
    int sx, sy, hs, vs, de, ls, fs, fc, r, g, b;
  } exp_t;

  localparam int D_HT = 800, D_VT = 525;
  localparam int S_HT = 14,  S_VT = 7;

`ifdef VGA_TIMING_PATTERN_EN
  localparam int P80_R = 31, P80_G = 63, P80_B = 0;
`else
  localparam int P80_R = 0,  P80_G = 0,  P80_B = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1, en_d = 1'b0;
  logic rst_s = 1'b1, en_s = 1'b0;

  logic [10:0] d_sx, d_sy;
  logic        d_hsync, d_vsync, d_de, d_ls, d_fs;
  logic [15:0] d_fc;
  logic [4:0]  d_r, d_b;
  logic [5:0]  d_g;

  logic [3:0]  s_sx, s_sy;
  logic        s_hsync, s_vsync, s_de, s_ls, s_fs;
  logic [1:0]  s_fc;
  logic [4:0]  s_r, s_b;
  logic [5:0]  s_g;

  vga_timing_gen u_def (
    .clk_pix(clk), .rst_pix(rst_d), .en(en_d),
    .sx(d_sx), .sy(d_sy), .hsync(d_hsync), .vsync(d_vsync), .de(d_de),
    .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc),
    .pat_r(d_r), .pat_g(d_g), .pat_b(d_b)
  );

  vga_timing_gen #(
    .CW(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .FRAME_CW(2)
  ) u_sml (
    .clk_pix(clk), .rst_pix(rst_s), .en(en_s),
    .sx(s_sx), .sy(s_sy), .hsync(s_hsync), .vsync(s_vsync), .de(s_de),
    .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc),
    .pat_r(s_r), .pat_g(s_g), .pat_b(s_b)
  );

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  exp_t q_d[$], q_s[$];
  exp_t last_d, last_s;
  int md_x = 0, md_y = 0, md_f = 0;
  int ms_x = 0, ms_y = 0, ms_f = 0;

  bit d_meas = 0, s_meas = 0;
  int d_de_cnt = 0, d_hs_cnt = 0, d_hs_min = 1000000, d_hs_max = -1;
  int d_ls_t0 = -1, d_ls_t1 = -1;
  int p80_r = -1, p80_g = -1, p80_b = -1, p639 = -1, p700 = -1;
  int s_hs_min = 1000000, s_hs_max = -1, s_vs_min = 1000000, s_vs_max = -1;
  int n_fs = 0;
  int fs_cyc[6];
  int fs_fc[6];

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void cmp(string tag, exp_t a, exp_t e);
    chk({tag, ".sx"}, a.sx, e.sx);
    chk({tag, ".sy"}, a.sy, e.sy);
    chk({tag, ".hsync"}, a.hs, e.hs);
    chk({tag, ".vsync"}, a.vs, e.vs);
    chk({tag, ".de"}, a.de, e.de);
    chk({tag, ".line_start"}, a.ls, e.ls);
    chk({tag, ".frame_start"}, a.fs, e.fs);
    chk({tag, ".frame_cnt"}, a.fc, e.fc);
    chk({tag, ".pat_r"}, a.r, e.r);
    chk({tag, ".pat_g"}, a.g, e.g);
    chk({tag, ".pat_b"}, a.b, e.b);
  endfunction

  // Expected output for scan position (x,y) of frame f.
  function automatic exp_t model(int x, int y, int f, int ha, int hf, int hsw,
                                 int va, int vf, int vsw, int hp, int vp, int fcw);
    exp_t e;
    e.sx = x;
    e.sy = y;
    e.hs = (x >= ha + hf && x < ha + hf + hsw) ? hp : 1 - hp;
    e.vs = (y >= va + vf && y < va + vf + vsw) ? vp : 1 - vp;
    e.de = (x < ha && y < va) ? 1 : 0;
    e.ls = (x == 0) ? 1 : 0;
    e.fs = (x == 0 && y == 0) ? 1 : 0;
    e.fc = f % (1 << fcw);
    e.r = 0; e.g = 0; e.b = 0;
`ifdef VGA_TIMING_PATTERN_EN
    if (e.de == 1) begin
      int bar;
      bar = 0;
      for (int k = 1; k < 8; k++) if (x >= k * ha / 8) bar = k;
      case (bar)
        0: begin e.r = 31; e.g = 63; e.b = 31; end
        1: begin e.r = 31; e.g = 63; end
        2: begin e.g = 63; e.b = 31; end
        3: begin e.g = 63; end
        4: begin e.r = 31; e.b = 31; end
        5: begin e.r = 31; end
        6: begin e.b = 31; end
        default: ;
      endcase
    end
`endif
    return e;
  endfunction

  function automatic exp_t reset_exp(int hp, int vp);
    exp_t e;
    e = '{default: 0};
    e.hs = 1 - hp;
    e.vs = 1 - vp;
    return e;
  endfunction

  function automatic exp_t pack_d();
    exp_t a;
    a.sx = int'(d_sx); a.sy = int'(d_sy); a.hs = int'(d_hsync); a.vs = int'(d_vsync);
    a.de = int'(d_de); a.ls = int'(d_ls); a.fs = int'(d_fs); a.fc = int'(d_fc);
    a.r = int'(d_r); a.g = int'(d_g); a.b = int'(d_b);
    return a;
  endfunction

  function automatic exp_t pack_s();
    exp_t a;
    a.sx = int'(s_sx); a.sy = int'(s_sy); a.hs = int'(s_hsync); a.vs = int'(s_vsync);
    a.de = int'(s_de); a.ls = int'(s_ls); a.fs = int'(s_fs); a.fc = int'(s_fc);
    a.r = int'(s_r); a.g = int'(s_g); a.b = int'(s_b);
    return a;
  endfunction

  task automatic step_d(input bit e);
    @(negedge clk);
    en_d = e;
    if (e) begin
      q_d.push_back(model(md_x, md_y, md_f, 640, 16, 96, 480, 10, 2, 0, 0, 16));
      md_x++;
      if (md_x == D_HT) begin
        md_x = 0; md_y++;
        if (md_y == D_VT) begin md_y = 0; md_f++; end
      end
    end
  endtask

  task automatic step_s(input bit e);
    @(negedge clk);
    en_s = e;
    if (e) begin
      q_s.push_back(model(ms_x, ms_y, ms_f, 8, 2, 2, 4, 1, 1, 1, 1, 2));
      ms_x++;
      if (ms_x == S_HT) begin
        ms_x = 0; ms_y++;
        if (ms_y == S_VT) begin ms_y = 0; ms_f++; end
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Default-instance monitor: pops on every enabled cycle, checks hold on stalls.
  bit   dm_en;
  exp_t dm_a, dm_e;
  always begin
    @(posedge clk);
    dm_en = en_d;
    #1;
    if (!rst_d) begin
      dm_a = pack_d();
      if (dm_en) begin
        if (q_d.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL def.sb_empty: output seen, expected none queued");
        end else begin
          dm_e = q_d.pop_front();
          cmp("def", dm_a, dm_e);
          last_d = dm_e;
        end
        if (d_meas) begin
          if (d_sy == 0 && d_de) d_de_cnt++;
          if (d_sy == 0 && !d_hsync) begin
            d_hs_cnt++;
            if (int'(d_sx) < d_hs_min) d_hs_min = int'(d_sx);
            if (int'(d_sx) > d_hs_max) d_hs_max = int'(d_sx);
          end
          if (d_ls) begin
            if (d_ls_t0 < 0) d_ls_t0 = cyc;
            else if (d_ls_t1 < 0) d_ls_t1 = cyc;
          end
          if (d_sy == 0 && d_sx == 80) begin
            p80_r = int'(d_r); p80_g = int'(d_g); p80_b = int'(d_b);
          end
          if (d_sy == 0 && d_sx == 639) p639 = int'({d_r, d_g, d_b});
          if (d_sy == 0 && d_sx == 700) p700 = int'({d_r, d_g, d_b});
        end
      end else begin
        dm_e = last_d;
        dm_e.ls = 0;
        dm_e.fs = 0;
        cmp("def.stall", dm_a, dm_e);
      end
    end
  end

  // Small-instance monitor.
  bit   sm_en;
  exp_t sm_a, sm_e;
  always begin
    @(posedge clk);
    sm_en = en_s;
    #1;
    if (!rst_s) begin
      sm_a = pack_s();
      if (sm_en) begin
        if (q_s.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sml.sb_empty: output seen, expected none queued");
        end else begin
          sm_e = q_s.pop_front();
          cmp("sml", sm_a, sm_e);
          last_s = sm_e;
        end
        if (s_meas) begin
          if (s_hsync) begin
            if (int'(s_sx) < s_hs_min) s_hs_min = int'(s_sx);
            if (int'(s_sx) > s_hs_max) s_hs_max = int'(s_sx);
          end
          if (s_vsync) begin
            if (int'(s_sy) < s_vs_min) s_vs_min = int'(s_sy);
            if (int'(s_sy) > s_vs_max) s_vs_max = int'(s_sy);
          end
          if (s_fs) begin
            if (n_fs < 6) begin
              fs_cyc[n_fs] = cyc;
              fs_fc[n_fs]  = int'(s_fc);
            end
            n_fs++;
          end
        end
      end else begin
        sm_e = last_s;
        sm_e.ls = 0;
        sm_e.fs = 0;
        cmp("sml.stall", sm_a, sm_e);
      end
    end
  end

  initial begin
    last_d = reset_exp(0, 0);
    last_s = reset_exp(1, 1);
    repeat (2) @(negedge clk);
    rst_d = 1'b0;
    rst_s = 1'b0;

    // Default timing: run part of a line, then reset asynchronously mid-line.
    repeat (300) step_d(1'b1);
    @(posedge clk);
    #3;
    rst_d = 1'b1;
    en_d  = 1'b0;
    #1;
    cmp("def.rst_async", pack_d(), reset_exp(0, 0));
    last_d = reset_exp(0, 0);
    md_x = 0; md_y = 0; md_f = 0;
    @(negedge clk);
    rst_d = 1'b0;

    d_meas = 1'b1;
    repeat (1700) step_d(1'b1);
    step_d(1'b0);
    d_meas = 1'b0;
    repeat (1000) step_d($urandom_range(0, 1) == 1);
    repeat (3) step_d(1'b0);

    // Small timing: async reset, five full frames, then random stalls.
    @(posedge clk);
    #3;
    rst_s = 1'b1;
    en_s  = 1'b0;
    #1;
    cmp("sml.rst_async", pack_s(), reset_exp(1, 1));
    last_s = reset_exp(1, 1);
    ms_x = 0; ms_y = 0; ms_f = 0;
    @(negedge clk);
    rst_s = 1'b0;

    s_meas = 1'b1;
    repeat (490) step_s(1'b1);
    step_s(1'b0);
    s_meas = 1'b0;
    repeat (300) step_s($urandom_range(0, 1) == 1);
    repeat (3) step_s(1'b0);

    chk("def.de_cycles_line0", d_de_cnt, 640);
    chk("def.hsync_low_cycles", d_hs_cnt, 96);
    chk("def.hsync_low_first_sx", d_hs_min, 656);
    chk("def.hsync_low_last_sx", d_hs_max, 751);
    chk("def.line_start_period", d_ls_t1 - d_ls_t0, 800);
    chk("def.pat_r_at_80", p80_r, P80_R);
    chk("def.pat_g_at_80", p80_g, P80_G);
    chk("def.pat_b_at_80", p80_b, P80_B);
    chk("def.pat_at_639", p639, 0);
    chk("def.pat_at_700", p700, 0);
    chk("sml.hsync_high_first_sx", s_hs_min, 10);
    chk("sml.hsync_high_last_sx", s_hs_max, 11);
    chk("sml.vsync_high_first_sy", s_vs_min, 5);
    chk("sml.vsync_high_last_sy", s_vs_max, 5);
    chk("sml.frame_start_count", n_fs, 5);
    chk("sml.frame_period_a", fs_cyc[1] - fs_cyc[0], 98);
    chk("sml.frame_period_b", fs_cyc[4] - fs_cyc[3], 98);
    chk("sml.frame_cnt_f0", fs_fc[0], 0);
    chk("sml.frame_cnt_f1", fs_fc[1], 1);
    chk("sml.frame_cnt_f2", fs_fc[2], 2);
    chk("sml.frame_cnt_f3", fs_fc[3], 3);
    chk("sml.frame_cnt_f4", fs_fc[4], 0);
    chk("def.sb_leftover", q_d.size(), 0);
    chk("sml.sb_leftover", q_s.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
